// File: rtl/tcnt_apb_mem_slave.sv
// APB4 completer backed by a word-addressed register memory, with programmable
// wait states, byte-lane writes, error responses and a saturating error counter.
module tcnt_apb_mem_slave #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 256,
   parameter int                    PROT_CHECK = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL   = {DATA_WIDTH{1'b0}},
   // Ceiling of err_cnt; lowered only in reduced builds to reach saturation quickly
   parameter logic [15:0]           ERR_SAT    = 16'hFFFF
) (
   input  logic                    pclk,
   input  logic                    prst,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [2:0]              pprot,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [3:0]              wait_cfg,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr,
   output logic [15:0]             err_cnt
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int OFF_W      = $clog2(STRB_WIDTH);
   localparam int IDX_W      = $clog2(DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_nxt_state;
   logic                    r_write;
   logic [IDX_W-1:0]        r_idx;
   logic [STRB_WIDTH-1:0]   r_strb;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic                    r_err;
   logic [3:0]              r_wcnt;
   logic                    r_pready;
   logic                    r_pslverr;
   logic [DATA_WIDTH-1:0]   r_prdata;
   logic [15:0]             r_err_cnt;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic                    w_setup;
   logic [IDX_W-1:0]        w_idx;
   logic                    w_misalign;
   logic                    w_oor;
   logic                    w_prot;
   logic                    w_err;
   logic                    w_complete;
   logic                    w_load;
   logic                    w_fire;
   logic [3:0]              w_nxt_wcnt;
   logic [IDX_W-1:0]        w_rd_idx;
   logic                    w_rd_err;
   logic                    w_rd_write;
   logic                    w_nxt_pready;
   logic                    w_nxt_pslverr;
   logic [DATA_WIDTH-1:0]   w_nxt_prdata;
   logic                    w_unused_prot;

   assign w_setup       = psel & ~penable;
   assign w_idx         = paddr[OFF_W +: IDX_W];
   assign w_misalign    = |(paddr & ADDR_WIDTH'(STRB_WIDTH - 1));
   assign w_oor         = |(paddr >> (OFF_W + IDX_W));
   assign w_prot        = (PROT_CHECK != 0) && pprot[1] && w_idx[IDX_W-1];
   assign w_err         = w_misalign | w_oor | w_prot;
   assign w_complete    = (r_state == ST_ACCESS) && r_pready;
   assign w_unused_prot = pprot[0] ^ pprot[2];

   // Next state, wait counter and the registered response to raise next cycle
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_wcnt  = r_wcnt;
      w_load      = 1'b0;
      w_fire      = 1'b0;
      w_rd_idx    = r_idx;
      w_rd_err    = r_err;
      w_rd_write  = r_write;
      case (r_state)
         ST_IDLE: begin
            if (w_setup) begin
               w_load      = 1'b1;
               w_nxt_state = ST_ACCESS;
               w_nxt_wcnt  = wait_cfg;
               w_fire      = (wait_cfg == 4'd0);
               w_rd_idx    = w_idx;
               w_rd_err    = w_err;
               w_rd_write  = pwrite;
            end else begin
               w_nxt_wcnt  = 4'd0;
            end
         end
         ST_ACCESS: begin
            if (r_pready || !psel) begin
               w_nxt_state = ST_IDLE;
               w_nxt_wcnt  = 4'd0;
            end else if (r_wcnt != 4'd0) begin
               w_nxt_wcnt  = r_wcnt - 4'd1;
               w_fire      = (r_wcnt == 4'd1);
            end else begin
               w_fire      = 1'b1;
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
            w_nxt_wcnt  = 4'd0;
         end
      endcase
      w_nxt_pready  = w_fire;
      w_nxt_pslverr = w_fire & w_rd_err;
      if (w_fire && !w_rd_err && !w_rd_write) begin
         w_nxt_prdata = r_mem[w_rd_idx];
      end else begin
         w_nxt_prdata = {DATA_WIDTH{1'b0}};
      end
   end

   // FSM state register
   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   // Setup-cycle capture, wait counter, registered response and error counter
   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         r_write   <= 1'b0;
         r_idx     <= {IDX_W{1'b0}};
         r_strb    <= {STRB_WIDTH{1'b0}};
         r_wdata   <= {DATA_WIDTH{1'b0}};
         r_err     <= 1'b0;
         r_wcnt    <= 4'd0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= {DATA_WIDTH{1'b0}};
         r_err_cnt <= 16'd0;
      end else begin
         if (w_load) begin
            r_write <= pwrite;
            r_idx   <= w_idx;
            r_strb  <= pstrb;
            r_wdata <= pwdata;
            r_err   <= w_err;
         end
         r_wcnt    <= w_nxt_wcnt;
         r_pready  <= w_nxt_pready;
         r_pslverr <= w_nxt_pslverr;
         r_prdata  <= w_nxt_prdata;
         if (w_complete && r_err && (r_err_cnt != ERR_SAT)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

   // Memory array: byte-lane write on an error-free write completion
   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         for (int j = 0; j < DEPTH; j++) begin
            r_mem[j] <= INIT_VAL;
         end
      end else if (w_complete && r_write && !r_err) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (r_strb[i]) begin
               r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

   assign prdata  = r_prdata;
   assign pready  = r_pready;
   assign pslverr = r_pslverr;
   assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_tcnt_apb_mem_slave.sv
// Bench for tcnt_apb_mem_slave: table of transfers checked through a scoreboard,
// plus abort, reset-during-access and error-counter saturation sequences.
module tb_tcnt_apb_mem_slave;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      logic [3:0]  waitc;
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic [15:0] exp_cnt;
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      logic        chk_data;
   } exp_t;

   logic        pclk = 1'b0;
   logic        prst, psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [2:0]  pprot;
   logic [3:0]  pstrb, wait_cfg;
   logic [31:0] prdata, s_prdata;
   logic        pready, pslverr, s_pready, s_pslverr;
   logic [15:0] err_cnt, s_err_cnt;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        sb_q[$];
   vec_t        vt [0:18];
   logic [31:0] last_sat_rdata;

   always #5 pclk = ~pclk;

   tcnt_apb_mem_slave u_dut (
      .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pprot(pprot), .pstrb(pstrb), .pwdata(pwdata), .wait_cfg(wait_cfg),
      .prdata(prdata), .pready(pready), .pslverr(pslverr), .err_cnt(err_cnt)
   );

   tcnt_apb_mem_slave #(.INIT_VAL(32'hDEAD_BEEF), .ERR_SAT(16'd3)) u_sat (
      .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pprot(pprot), .pstrb(pstrb), .pwdata(pwdata), .wait_cfg(wait_cfg),
      .prdata(s_prdata), .pready(s_pready), .pslverr(s_pslverr), .err_cnt(s_err_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [2:0] p, input logic [3:0] w,
                               input logic e, input logic [31:0] r, input logic [15:0] c);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = d; v.strb = s; v.prot = p; v.waitc = w;
      v.exp_err = e; v.exp_rdata = r; v.exp_cnt = c;
      return v;
   endfunction

   // One APB transfer; entered and left #1 after a rising edge, so calls chain back-to-back
   task automatic xfer(input vec_t v, input string tag);
      exp_t e;
      int   waits;
      bit   done;
      psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr; pprot = v.prot;
      pstrb = v.strb; pwdata = v.wdata; wait_cfg = v.waitc;
      sb_q.push_back('{err: v.exp_err, rdata: v.exp_rdata, chk_data: (!v.wr || v.exp_err)});
      @(posedge pclk); #1;
      penable = 1'b1; wait_cfg = ~v.waitc; pwdata = ~v.wdata;
      waits = 0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge pclk);
         if (pready) done = 1'b1;
         else waits++;
      end
      e = sb_q.pop_front();
      if (done) begin
         check({tag, "_waits"}, waits, {28'd0, v.waitc});
         check({tag, "_pslverr"}, {31'd0, pslverr}, {31'd0, e.err});
         if (e.chk_data) check({tag, "_prdata"}, prdata, e.rdata);
         last_sat_rdata = s_prdata;
         @(posedge pclk); #1;
         check({tag, "_pready_pulse"}, {31'd0, pready}, 32'd0);
         check({tag, "_err_cnt"}, {16'd0, err_cnt}, {16'd0, v.exp_cnt});
      end else begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic any_ready;
      prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0;
      pprot = 3'd0; pstrb = 4'd0; pwdata = 32'd0; wait_cfg = 4'd0;
      last_sat_rdata = 32'd0;

      //        wr    addr          wdata         strb     prot     wait   err   rdata         cnt
      vt[0]  = mk(1'b0, 32'h0000_0000, 32'h0,        4'hF, 3'b000, 4'd0,  1'b0, 32'h0000_0000, 16'd0);
      vt[1]  = mk(1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'h5, 3'b000, 4'd1,  1'b0, 32'h0,        16'd0);
      vt[2]  = mk(1'b0, 32'h0000_0010, 32'h0,        4'hF, 3'b000, 4'd0,  1'b0, 32'h00A5_0034, 16'd0);
      vt[3]  = mk(1'b1, 32'h0000_0014, 32'h1122_3344, 4'hF, 3'b000, 4'd2,  1'b0, 32'h0,        16'd0);
      vt[4]  = mk(1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'h8, 3'b000, 4'd0,  1'b0, 32'h0,        16'd0);
      vt[5]  = mk(1'b0, 32'h0000_0014, 32'h0,        4'hF, 3'b000, 4'd5,  1'b0, 32'hAA22_3344, 16'd0);
      vt[6]  = mk(1'b1, 32'h0000_0018, 32'hFFFF_FFFF, 4'h0, 3'b000, 4'd3,  1'b0, 32'h0,        16'd0);
      vt[7]  = mk(1'b0, 32'h0000_0018, 32'h0,        4'hF, 3'b000, 4'd15, 1'b0, 32'h0000_0000, 16'd0);
      vt[8]  = mk(1'b1, 32'h0000_0003, 32'h1234_5678, 4'hF, 3'b000, 4'd0,  1'b1, 32'h0,        16'd1);
      vt[9]  = mk(1'b0, 32'h0000_0400, 32'h0,        4'hF, 3'b000, 4'd1,  1'b1, 32'h0,        16'd2);
      vt[10] = mk(1'b1, 32'h0000_0200, 32'hCAFE_0001, 4'hF, 3'b010, 4'd0,  1'b1, 32'h0,        16'd3);
      vt[11] = mk(1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 3'b000, 4'd2,  1'b0, 32'h0,        16'd3);
      vt[12] = mk(1'b0, 32'h0000_0200, 32'h0,        4'h0, 3'b000, 4'd0,  1'b0, 32'h1234_5678, 16'd3);
      vt[13] = mk(1'b0, 32'h0000_01FC, 32'h0,        4'hF, 3'b010, 4'd0,  1'b0, 32'h0000_0000, 16'd3);
      vt[14] = mk(1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 4'hF, 3'b000, 4'd1,  1'b0, 32'h0,        16'd3);
      vt[15] = mk(1'b0, 32'h0000_03FC, 32'h0,        4'hF, 3'b000, 4'd0,  1'b0, 32'h0BAD_F00D, 16'd3);
      vt[16] = mk(1'b0, 32'h0000_03FE, 32'h0,        4'hF, 3'b000, 4'd0,  1'b1, 32'h0,        16'd4);
      vt[17] = mk(1'b0, 32'h0000_0000, 32'h0,        4'hF, 3'b010, 4'd0,  1'b0, 32'h0000_0000, 16'd4);
      vt[18] = mk(1'b0, 32'h0000_0200, 32'h0,        4'hF, 3'b010, 4'd2,  1'b1, 32'h0,        16'd5);

      repeat (3) @(posedge pclk);
      #1;
      check("rst_pready", {31'd0, pready}, 32'd0);
      check("rst_pslverr", {31'd0, pslverr}, 32'd0);
      check("rst_prdata", prdata, 32'd0);
      check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      prst = 1'b0;
      @(posedge pclk); #1;

      for (int i = 0; i < 19; i++) begin
         xfer(vt[i], $sformatf("v%0d", i));
      end

      // Abort: drop psel during the wait states of a write
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pprot = 3'b000;
      pstrb = 4'hF; pwdata = 32'h5555_AAAA; wait_cfg = 4'd4;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      any_ready = 1'b0;
      repeat (6) begin
         @(negedge pclk);
         if (pready) any_ready = 1'b1;
      end
      check("abort_no_pready", {31'd0, any_ready}, 32'd0);
      check("abort_err_cnt", {16'd0, err_cnt}, 32'd5);
      @(posedge pclk); #1;
      xfer(mk(1'b0, 32'h20, 32'h0, 4'hF, 3'b000, 4'd0, 1'b0, 32'h0, 16'd5), "abort_rd");

      // Reset during the access phase of a write with three wait states
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pprot = 3'b000;
      pstrb = 4'hF; pwdata = 32'hFFFF_FFFF; wait_cfg = 4'd3;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      prst = 1'b1;
      #1;
      check("midrst_pready", {31'd0, pready}, 32'd0);
      check("midrst_err_cnt", {16'd0, err_cnt}, 32'd0);
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      prst = 1'b0;
      @(posedge pclk); #1;
      xfer(mk(1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 4'd0, 1'b0, 32'h0, 16'd0), "midrst_rd10");
      check("sat_init_val", last_sat_rdata, 32'hDEAD_BEEF);
      xfer(mk(1'b0, 32'h14, 32'h0, 4'hF, 3'b000, 4'd1, 1'b0, 32'h0, 16'd0), "midrst_rd14");

      // Error counter saturation on the reduced-ceiling instance
      for (int k = 1; k <= 5; k++) begin
         xfer(mk(1'b0, 32'h400, 32'h0, 4'hF, 3'b000, 4'd0, 1'b1, 32'h0, 16'(k)),
              $sformatf("sat%0d", k));
         check($sformatf("sat%0d_hold", k), {16'd0, s_err_cnt}, (k < 3) ? k : 3);
      end

      if (sb_q.size() != 0) check("sb_empty", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
